// File: rtl/vstore_pkg.sv
// Shared types and default sizing for the vector store engine.
package vstore_pkg;

   localparam int unsigned DEF_LANES  = 4;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DEPTH  = 1024;
   localparam int unsigned LANE_W     = (DEF_LANES > 1) ? $clog2(DEF_LANES) : 1;

   typedef logic [LANE_W-1:0] lane_idx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/vstore_lane_pick.sv
// Priority encoder: lowest enabled lane (start=1) or next enabled lane above cur.
module vstore_lane_pick
   import vstore_pkg::*;
#(
   parameter int unsigned LANES = DEF_LANES,
   localparam int unsigned LW   = (LANES > 1) ? $clog2(LANES) : 1
)(
   input  logic [LANES-1:0] mask,
   input  logic [LW-1:0]    cur,
   input  logic             start,
   output logic [LW-1:0]    nxt_c,
   output logic             none_left_c
);

   // Scan downwards so the lowest qualifying lane wins.
   always_comb begin
      nxt_c       = '0;
      none_left_c = 1'b1;
      for (int i = int'(LANES) - 1; i >= 0; i--) begin
         if (mask[i] && (start || (i > int'(cur)))) begin
            nxt_c       = LW'(i);
            none_left_c = 1'b0;
         end
      end
   end

endmodule

// File: rtl/vec_store_unit.sv
// Vector store engine: serializes enabled lanes of one request into single-word
// memory writes, skipping and flagging lanes whose address falls outside memory.
module vec_store_unit
   import vstore_pkg::*;
#(
   parameter int unsigned LANES  = DEF_LANES,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_W-1:0]       req_base,
   input  logic [ADDR_W-1:0]       req_stride,
   input  logic [LANES*DATA_W-1:0] req_data,
   input  logic [LANES-1:0]        req_mask,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic                    mem_ready,
   output logic                    done,
   output logic                    err
);

   localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       base_q, stride_q;
   logic [LANES*DATA_W-1:0] data_q;
   logic [LANES-1:0]        mask_q;
   logic [LW-1:0]           lane_q, lane_d;
   logic                    sticky_q, sticky_d;
   logic                    load_c;

   logic                    mem_we_d, done_d, err_d, req_ready_d;
   logic [ADDR_W-1:0]       mem_addr_d;
   logic [DATA_W-1:0]       mem_wdata_d;

   logic                    idle_c;
   logic [LANES-1:0]        pick_mask_c;
   logic [LW-1:0]           pick_nxt_c;
   logic                    pick_none_c;
   logic [ADDR_W-1:0]       sel_base_c, sel_stride_c, lane_addr_c;
   logic [LANES*DATA_W-1:0] sel_data_c;
   logic [DATA_W-1:0]       lane_words_c [LANES];
   logic                    in_range_c;
   logic                    sticky_nxt_c;

   // In IDLE the first lane is derived straight from the request inputs so
   // the first write can appear in the cycle right after the accept edge.
   assign idle_c       = (state_q == IDLE);
   assign pick_mask_c  = idle_c ? req_mask   : mask_q;
   assign sel_base_c   = idle_c ? req_base   : base_q;
   assign sel_stride_c = idle_c ? req_stride : stride_q;
   assign sel_data_c   = idle_c ? req_data   : data_q;

   vstore_lane_pick #(.LANES(LANES)) u_pick (
      .mask        (pick_mask_c),
      .cur         (lane_q),
      .start       (idle_c),
      .nxt_c       (pick_nxt_c),
      .none_left_c (pick_none_c)
   );

   always_comb begin
      for (int i = 0; i < int'(LANES); i++) begin
         lane_words_c[i] = sel_data_c[i*DATA_W +: DATA_W];
      end
   end

   // Address arithmetic wraps modulo 2^ADDR_W.
   assign lane_addr_c = sel_base_c + (sel_stride_c * ADDR_W'(pick_nxt_c));
   assign in_range_c  = (lane_addr_c < ADDR_W'(DEPTH));

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      sticky_d     = sticky_q;
      load_c       = 1'b0;
      mem_we_d     = mem_we;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      done_d       = 1'b0;
      err_d        = 1'b0;
      req_ready_d  = 1'b0;
      sticky_nxt_c = sticky_q;

      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            mem_we_d    = 1'b0;
            if (req_valid && req_ready) begin
               load_c      = 1'b1;
               req_ready_d = 1'b0;
               if (pick_none_c) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d     = BUSY;
                  lane_d      = pick_nxt_c;
                  mem_we_d    = in_range_c;
                  mem_addr_d  = lane_addr_c;
                  mem_wdata_d = lane_words_c[pick_nxt_c];
               end
            end
         end

         BUSY: begin
            // Out-of-range lanes (mem_we=0) retire without waiting for memory.
            if (mem_ready || !mem_we) begin
               sticky_nxt_c = sticky_q | ~mem_we;
               sticky_d     = sticky_nxt_c;
               if (pick_none_c) begin
                  state_d  = DONE;
                  mem_we_d = 1'b0;
                  done_d   = 1'b1;
                  err_d    = sticky_nxt_c;
               end else begin
                  lane_d      = pick_nxt_c;
                  mem_we_d    = in_range_c;
                  mem_addr_d  = lane_addr_c;
                  mem_wdata_d = lane_words_c[pick_nxt_c];
               end
            end
         end

         DONE: begin
            state_d     = IDLE;
            sticky_d    = 1'b0;
            mem_we_d    = 1'b0;
            req_ready_d = 1'b1;
         end

         default: begin
            state_d  = IDLE;
            sticky_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         base_q    <= '0;
         stride_q  <= '0;
         data_q    <= '0;
         mask_q    <= '0;
         lane_q    <= '0;
         sticky_q  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         req_ready <= 1'b0;
      end else begin
         state_q   <= state_d;
         lane_q    <= lane_d;
         sticky_q  <= sticky_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         done      <= done_d;
         err       <= err_d;
         req_ready <= req_ready_d;
         if (load_c) begin
            base_q   <= req_base;
            stride_q <= req_stride;
            data_q   <= req_data;
            mask_q   <= req_mask;
         end
      end
   end

endmodule

// File: tb/tb_vec_store_unit.sv
// Randomized self-checking bench for vec_store_unit against a queue-based write-list model.
module tb_vec_store_unit;

   localparam int unsigned LANES  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DEPTH  = 1024;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    req_valid;
   logic                    req_ready;
   logic [ADDR_W-1:0]       req_base;
   logic [ADDR_W-1:0]       req_stride;
   logic [LANES*DATA_W-1:0] req_data;
   logic [LANES-1:0]        req_mask;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic                    mem_ready;
   logic                    done;
   logic                    err;

   int n_total = 0;
   int n_pass  = 0;

   vec_store_unit #(
      .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_base   (req_base),
      .req_stride (req_stride),
      .req_data   (req_data),
      .req_mask   (req_mask),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!req_ready && k < 20) begin
         step();
         k++;
      end
      check("ready_wait", 32'(req_ready), 32'd1);
   endtask

   // Issue one request and check the full write sequence, latency and status.
   task automatic do_req(input logic [31:0] base, input logic [31:0] stride,
                         input logic [127:0] data, input logic [3:0] mask,
                         input bit bp);
      logic [31:0] exp_addr[$];
      logic [31:0] exp_data[$];
      logic [31:0] a;
      logic [31:0] w;
      logic        exp_err = 1'b0;
      int          n_en    = 0;
      int          stalls  = 0;
      bit          prev_stall = 0;
      bit          seen_done  = 0;
      logic [31:0] hold_addr = '0;
      logic [31:0] hold_data = '0;

      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            n_en++;
            a = base + (32'(i) * stride);
            w = data[i*32 +: 32];
            if (a < 32'(DEPTH)) begin
               exp_addr.push_back(a);
               exp_data.push_back(w);
            end else begin
               exp_err = 1'b1;
            end
         end
      end

      wait_ready();
      req_valid  = 1'b1;
      req_base   = base;
      req_stride = stride;
      req_data   = data;
      req_mask   = mask;
      step();
      req_valid  = 1'b0;
      req_base   = $urandom;
      req_stride = $urandom;
      req_data   = {$urandom, $urandom, $urandom, $urandom};
      req_mask   = 4'($urandom);

      for (int k = 1; k < 200; k++) begin
         if (prev_stall) begin
            check("stall_we",   32'(mem_we), 32'd1);
            check("stall_addr", mem_addr, hold_addr);
            check("stall_data", mem_wdata, hold_data);
         end
         if (done) begin
            seen_done = 1;
            check("done_lat",  32'(k), 32'(1 + n_en + stalls));
            check("err",       32'(err), 32'(exp_err));
            check("leftover",  32'(exp_addr.size()), 32'd0);
            check("rdy_in_done", 32'(req_ready), 32'd0);
            check("we_in_done",  32'(mem_we), 32'd0);
            break;
         end
         mem_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         prev_stall = 0;
         if (mem_we) begin
            if (mem_ready) begin
               if (exp_addr.size() == 0) begin
                  check("extra_wr", mem_addr, 32'hDEAD_BEEF);
               end else begin
                  check("wr_addr", mem_addr,  exp_addr.pop_front());
                  check("wr_data", mem_wdata, exp_data.pop_front());
               end
            end else begin
               stalls++;
               prev_stall = 1;
               hold_addr  = mem_addr;
               hold_data  = mem_wdata;
            end
         end
         step();
      end
      check("done_seen", 32'(seen_done), 32'd1);
      mem_ready = 1'b1;
      step();
      check("done_pulse",  32'(done), 32'd0);
      check("ready_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [127:0] d;
      logic [31:0]  b, s;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_base   = '0;
      req_stride = '0;
      req_data   = '0;
      req_mask   = '0;
      mem_ready  = 1'b1;
      step();
      step();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_we",    32'(mem_we),    32'd0);
      check("rst_addr",  mem_addr,       32'd0);
      check("rst_wdata", mem_wdata,      32'd0);
      check("rst_done",  32'(done),      32'd0);
      check("rst_err",   32'(err),       32'd0);
      rst_n = 1'b1;
      step();
      check("post_rst_ready", 32'(req_ready), 32'd1);

      // Directed cases
      d = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
      do_req(32'h10,  32'd1,        d, 4'b1111, 0);
      do_req(32'h20,  32'd4,        d, 4'b1010, 0);
      do_req(32'h55,  32'd3,        d, 4'b0000, 0);
      do_req(32'h3FE, 32'd1,        d, 4'b1111, 0);
      do_req(32'h100, 32'd2,        d, 4'b0101, 0);
      do_req(32'd2,   32'hFFFF_FFFF, d, 4'b1111, 0);
      do_req(32'h3FF, 32'd0,        d, 4'b1001, 1);

      // Stall on lane 0 then reset during lane 1
      wait_ready();
      req_valid = 1'b1; req_base = 32'h10; req_stride = 32'd1;
      req_data = d; req_mask = 4'b1111;
      mem_ready = 1'b0;
      step();
      req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("hold_we",   32'(mem_we), 32'd1);
         check("hold_addr", mem_addr,    32'h10);
         check("hold_data", mem_wdata,   32'hA0A0_0000);
         step();
      end
      check("hold_addr_end", mem_addr, 32'h10);
      mem_ready = 1'b1;
      step();
      check("lane1_addr", mem_addr,  32'h11);
      check("lane1_data", mem_wdata, 32'hA1A1_0001);
      mem_ready = 1'b0;
      rst_n = 1'b0;
      step();
      check("abort_we",    32'(mem_we),    32'd0);
      check("abort_done",  32'(done),      32'd0);
      check("abort_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      step();
      check("abort_idle_ready", 32'(req_ready), 32'd1);
      check("abort_idle_done",  32'(done),      32'd0);
      check("abort_idle_we",    32'(mem_we),    32'd0);
      step();
      check("abort_no_done", 32'(done), 32'd0);

      // Randomized requests with random backpressure
      for (int t = 0; t < 60; t++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         b = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1100));
         case ($urandom_range(0, 4))
            0:       s = 32'd1;
            1:       s = 32'd4;
            2:       s = 32'hFFFF_FFFF;
            3:       s = $urandom;
            default: s = 32'($urandom_range(0, 300));
         endcase
         do_req(b, s, d, 4'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
